time_set_controller: RTL and testbench

Mode and increment sequencer for the clock's time-keeping datapath. It sits between the clock divider, the debounced user buttons and the second/minute/hour counter chain. In run mode it forwards the 1 Hz tick to the second counter. In set modes it freezes seconds and converts button presses, including auto-repeat on hold, into single-cycle minute or hour increment strobes.

---
 rtl/time_set_controller.sv | 190 +++++++++++++++++++
 tb/tb_time_set_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/time_set_controller.sv
// Run/set mode sequencer for the time-keeping chain: forwards ticks in RUN, emits minute/hour increments in set modes.
// Optional hold-to-repeat on the increment button is enabled by defining AUTO_REPEAT_EN.
module time_set_controller #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       sec_pulse,
  output logic       sec_clear,
  output logic       min_inc,
  output logic       hr_inc,
  output logic [1:0] set_mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_MIN = 2'b01,
    SET_HR  = 2'b10
  } state_t;

  state_t state_r, state_s;
  logic   mode_prev_r, inc_prev_r;
  logic   mode_rise_s, inc_rise_s;
  logic   repeat_fire_s;
  logic   inc_strobe_s;
  logic   sec_pulse_s, sec_clear_s, min_inc_s, hr_inc_s, blink_s;
  logic   sec_pulse_r, sec_clear_r, min_inc_r, hr_inc_r, blink_r;

  assign mode_rise_s = btn_mode & ~mode_prev_r;
  assign inc_rise_s  = btn_inc & ~inc_prev_r;

  // Edge-detector history; resets high so a button held through reset gives no edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_prev_r <= 1'b1;
      inc_prev_r  <= 1'b1;
    end else begin
      mode_prev_r <= btn_mode;
      inc_prev_r  <= btn_inc;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
  logic             rep_phase_r, rep_phase_s;
  logic             armed_r, armed_s;

  // Counter holds (cycles since last strobe - 1); first expiry uses HOLD, later ones REPEAT.
  always_comb begin
    repeat_fire_s = 1'b0;
    if (armed_r && btn_inc) begin
      if (rep_phase_r) begin
        repeat_fire_s = (hold_cnt_r == REPEAT_LAST);
      end else begin
        repeat_fire_s = (hold_cnt_r == HOLD_LAST);
      end
    end else begin
      repeat_fire_s = 1'b0;
    end
  end

  // Hold counter next state; any mode change or release disarms it until a fresh press.
  always_comb begin
    hold_cnt_s  = hold_cnt_r;
    rep_phase_s = rep_phase_r;
    armed_s     = armed_r;
    if (mode_rise_s || (state_r == RUN) || !btn_inc) begin
      hold_cnt_s  = CNT_ZERO;
      rep_phase_s = 1'b0;
      armed_s     = 1'b0;
    end else if (inc_rise_s) begin
      hold_cnt_s  = CNT_ZERO;
      rep_phase_s = 1'b0;
      armed_s     = 1'b1;
    end else if (repeat_fire_s) begin
      hold_cnt_s  = CNT_ZERO;
      rep_phase_s = 1'b1;
    end else if (armed_r && (hold_cnt_r != CNT_MAX)) begin
      hold_cnt_s  = hold_cnt_r + CNT_ONE;
    end else begin
      hold_cnt_s  = hold_cnt_r;
    end
  end

  // Hold counter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt_r  <= CNT_ZERO;
      rep_phase_r <= 1'b0;
      armed_r     <= 1'b0;
    end else begin
      hold_cnt_r  <= hold_cnt_s;
      rep_phase_r <= rep_phase_s;
      armed_r     <= armed_s;
    end
  end
`else
  assign repeat_fire_s = 1'b0;
`endif

  // Mode FSM and strobe decode; a mode rise swallows every other event in its cycle.
  always_comb begin
    state_s      = state_r;
    sec_pulse_s  = 1'b0;
    sec_clear_s  = 1'b0;
    inc_strobe_s = 1'b0;
    blink_s      = blink_r;
    if (mode_rise_s) begin
      case (state_r)
        RUN: begin
          state_s     = SET_MIN;
          sec_clear_s = 1'b1;
          blink_s     = 1'b0;
        end
        SET_MIN: begin
          state_s = SET_HR;
        end
        SET_HR: begin
          state_s = RUN;
          blink_s = 1'b0;
        end
        default: begin
          state_s = RUN;
          blink_s = 1'b0;
        end
      endcase
    end else begin
      case (state_r)
        RUN: begin
          sec_pulse_s = tick;
          blink_s     = 1'b0;
        end
        SET_MIN, SET_HR: begin
          if (tick) begin
            blink_s = ~blink_r;
          end else begin
            blink_s = blink_r;
          end
          inc_strobe_s = inc_rise_s | repeat_fire_s;
        end
        default: begin
          state_s = RUN;
          blink_s = 1'b0;
        end
      endcase
    end
    min_inc_s = inc_strobe_s & (state_r == SET_MIN);
    hr_inc_s  = inc_strobe_s & (state_r == SET_HR);
  end

  // Registered state and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= RUN;
      sec_pulse_r <= 1'b0;
      sec_clear_r <= 1'b0;
      min_inc_r   <= 1'b0;
      hr_inc_r    <= 1'b0;
      blink_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      sec_pulse_r <= sec_pulse_s;
      sec_clear_r <= sec_clear_s;
      min_inc_r   <= min_inc_s;
      hr_inc_r    <= hr_inc_s;
      blink_r     <= blink_s;
    end
  end

  assign sec_pulse = sec_pulse_r;
  assign sec_clear = sec_clear_r;
  assign min_inc   = min_inc_r;
  assign hr_inc    = hr_inc_r;
  assign set_mode  = state_r;
  assign blink     = blink_r;

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench for time_set_controller: stimulus queues expected strobes, a negedge monitor pops and compares.
module tb_time_set_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       sec_pulse, sec_clear, min_inc, hr_inc, blink;
  logic [1:0] set_mode;

  time_set_controller #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_pulse(sec_pulse), .sec_clear(sec_clear), .min_inc(min_inc), .hr_inc(hr_inc),
    .set_mode(set_mode), .blink(blink)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] strb;
    logic [1:0] mode;
    int         cyc;
  } exp_t;

  localparam logic [3:0] S_SEC = 4'b1000;
  localparam logic [3:0] S_CLR = 4'b0100;
  localparam logic [3:0] S_MIN = 4'b0010;
  localparam logic [3:0] S_HR  = 4'b0001;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   p;

  task automatic expect_at(input logic [3:0] s, input logic [1:0] m, input int c);
    exp_t e;
    e.strb = s;
    e.mode = m;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic drive(input logic t, input logic m, input logic i);
    @(posedge clk);
    #1;
    tick = t;
    btn_mode = m;
    btn_inc = i;
  endtask

  // Monitor: every strobe the DUT presents must match the head of the queue.
  always @(negedge clk) begin : mon
    logic [3:0] s;
    exp_t e;
    s = {sec_pulse, sec_clear, min_inc, hr_inc};
    if (s !== 4'b0000) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe actual=%b mode=%b cycle=%0d required=none", s, set_mode, cyc);
      end else begin
        e = q.pop_front();
        if (s !== e.strb || set_mode !== e.mode || cyc != e.cyc) begin
          bad++;
          $display("FAIL strobe actual=%b/%b@%0d required=%b/%b@%0d",
                   s, set_mode, cyc, e.strb, e.mode, e.cyc);
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_strobes", {sec_pulse, sec_clear, min_inc, hr_inc}, 4'b0000);
    check("reset_mode", {2'b00, set_mode}, 4'b0000);
    check("reset_blink", {3'b000, blink}, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // RUN: three ticks, each forwarded one cycle later
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      expect_at(S_SEC, 2'b00, cyc + 1);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
    end
    check("run_mode", {2'b00, set_mode}, 4'b0000);
    check("run_blink", {3'b000, blink}, 4'b0000);

    // Mode rise with a tick: sec_clear only, tick dropped
    drive(1'b1, 1'b1, 1'b0);
    expect_at(S_CLR, 2'b01, cyc + 1);
    drive(1'b0, 1'b0, 1'b0);
    check("enter_set_min", {2'b00, set_mode}, 4'b0001);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("blink_toggle1", {3'b000, blink}, 4'b0001);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("blink_toggle2", {3'b000, blink}, 4'b0000);

    // Hold btn_inc for 20 sampled edges
    drive(1'b0, 1'b0, 1'b1);
    p = cyc + 1;
    expect_at(S_MIN, 2'b01, p);
`ifdef AUTO_REPEAT_EN
    expect_at(S_MIN, 2'b01, p + 8);
    expect_at(S_MIN, 2'b01, p + 12);
    expect_at(S_MIN, 2'b01, p + 16);
`endif
    repeat (19) drive(1'b0, 1'b0, 1'b1);
    repeat (6) drive(1'b0, 1'b0, 1'b0);

    // Mode and inc rise together: mode wins, no increment
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("enter_set_hr", {2'b00, set_mode}, 4'b0010);
    drive(1'b0, 1'b0, 1'b1);
    expect_at(S_HR, 2'b10, cyc + 1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("blink_set_hr", {3'b000, blink}, 4'b0001);
    // Leave SET_HR with a tick in the same cycle: tick dropped, blink cleared
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("back_to_run", {2'b00, set_mode}, 4'b0000);
    check("run_blink_cleared", {3'b000, blink}, 4'b0000);
    repeat (2) drive(1'b0, 1'b0, 1'b0);

    // Reset mid-hold in SET_HR with btn_mode held through release
    drive(1'b0, 1'b1, 1'b0);
    expect_at(S_CLR, 2'b01, cyc + 1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("reach_set_hr", {2'b00, set_mode}, 4'b0010);
    drive(1'b0, 1'b0, 1'b1);
    expect_at(S_HR, 2'b10, cyc + 1);
    repeat (5) drive(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    btn_mode = 1'b1;
    #1;
    check("async_rst_mode", {2'b00, set_mode}, 4'b0000);
    check("async_rst_strobes", {sec_pulse, sec_clear, min_inc, hr_inc}, 4'b0000);
    repeat (3) drive(1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (12) drive(1'b0, 1'b1, 1'b1);
    check("no_advance_after_rst", {2'b00, set_mode}, 4'b0000);
    check("blink_after_rst", {3'b000, blink}, 4'b0000);
    repeat (4) drive(1'b0, 1'b0, 1'b0);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_strobes actual=%0d pending required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
